// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV64 pipeline.
// Runs one req/ack data-bus transaction per load/store, formats store lanes
// and load results, and stalls upstream while a transaction is outstanding.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_memtoreg,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [63:0] read_data_out,
  output logic [63:0] result_alu_out,
  output logic [4:0]  rd_out,
  output logic        memtoreg_out,
  output logic        regwrite_out,
  output logic        mem_fault,
  output logic        bus_err
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                err;
  logic [XLEN-1:0]     lat_addr;
  logic [XLEN-1:0]     lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;
  logic                lat_we;
  logic [2:0]          lat_funct3;
  logic [2:0]          lat_off;
  logic [4:0]          lat_rd;
  logic                lat_memtoreg;
  logic                lat_regwrite;
  logic [XLEN-1:0]     lat_alu;
  logic [XLEN-1:0]     lat_rdata;

  logic                mem_op;
  logic [2:0]          off;
  logic                misaligned;
  logic [XLEN-1:0]     fmt_wdata;
  logic [STRB_W-1:0]   fmt_wstrb;
  logic [XLEN-1:0]     ld_shift;
  logic [XLEN-1:0]     ld_fmt;

  assign mem_op = ex_valid & (ex_memread | ex_memwrite);
  assign off    = ex_alu_result[2:0];

  // Alignment check by access size; funct3 111 is always illegal.
  always_comb begin
    misaligned = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off[1:0] != 2'b00);
      2'b11:   misaligned = (off != 3'b000);
      default: misaligned = 1'b0;
    endcase
    if (ex_funct3 == 3'b111) misaligned = 1'b1;
  end

  // Store lane replication and byte-enable generation.
  always_comb begin
    fmt_wdata = ex_store_data;
    fmt_wstrb = 8'hFF;
    case (ex_funct3[1:0])
      2'b00: begin
        fmt_wdata = {8{ex_store_data[7:0]}};
        fmt_wstrb = STRB_W'(8'h01 << off);
      end
      2'b01: begin
        fmt_wdata = {4{ex_store_data[15:0]}};
        fmt_wstrb = STRB_W'(8'h03 << off);
      end
      2'b10: begin
        fmt_wdata = {2{ex_store_data[31:0]}};
        fmt_wstrb = STRB_W'(8'h0F << off);
      end
      default: begin
        fmt_wdata = ex_store_data;
        fmt_wstrb = 8'hFF;
      end
    endcase
  end

  assign ld_shift = dmem_rdata >> {lat_off, 3'b000};

  // Load extraction with sign/zero extension from the latched access size.
  always_comb begin
    ld_fmt = ld_shift;
    case (lat_funct3)
      3'b000:  ld_fmt = {{56{ld_shift[7]}},  ld_shift[7:0]};
      3'b001:  ld_fmt = {{48{ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_fmt = {{32{ld_shift[31]}}, ld_shift[31:0]};
      3'b100:  ld_fmt = {56'd0, ld_shift[7:0]};
      3'b101:  ld_fmt = {48'd0, ld_shift[15:0]};
      3'b110:  ld_fmt = {32'd0, ld_shift[31:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  // Transaction FSM with request latches and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      err          <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_wstrb    <= '0;
      lat_we       <= 1'b0;
      lat_funct3   <= '0;
      lat_off      <= '0;
      lat_rd       <= '0;
      lat_memtoreg <= 1'b0;
      lat_regwrite <= 1'b0;
      lat_alu      <= '0;
      lat_rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op && !misaligned) begin
            lat_addr     <= {ex_alu_result[63:3], 3'b000};
            lat_wdata    <= fmt_wdata;
            lat_wstrb    <= fmt_wstrb;
            lat_we       <= ex_memwrite;
            lat_funct3   <= ex_funct3;
            lat_off      <= off;
            lat_rd       <= ex_rd;
            lat_memtoreg <= ex_memtoreg;
            lat_regwrite <= ex_regwrite;
            lat_alu      <= ex_alu_result;
            lat_rdata    <= '0;
            cnt          <= '0;
            err          <= 1'b0;
            state        <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            lat_rdata <= lat_we ? '0 : ld_fmt;
            state     <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output selection: pass-through in IDLE, latched values otherwise.
  // A stalled slot is presented to MEM/WB as a bubble (no register write).
  always_comb begin
    dmem_req       = (state == S_BUSY);
    dmem_we        = lat_we;
    dmem_addr      = lat_addr;
    dmem_wdata     = lat_wdata;
    dmem_wstrb     = lat_wstrb;
    stall          = 1'b0;
    mem_fault      = 1'b0;
    bus_err        = 1'b0;
    read_data_out  = '0;
    result_alu_out = ex_alu_result;
    rd_out         = ex_rd;
    memtoreg_out   = ex_memtoreg;
    regwrite_out   = ex_valid & ex_regwrite;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          regwrite_out = 1'b0;
          if (misaligned) mem_fault = ~reset;
          else            stall     = ~reset;
        end
      end
      S_BUSY: begin
        stall          = 1'b1;
        result_alu_out = lat_alu;
        rd_out         = lat_rd;
        memtoreg_out   = lat_memtoreg;
        regwrite_out   = 1'b0;
      end
      S_DONE: begin
        result_alu_out = lat_alu;
        rd_out         = lat_rd;
        memtoreg_out   = lat_memtoreg;
        read_data_out  = lat_rdata;
        regwrite_out   = lat_regwrite & ~err;
        bus_err        = err;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector bench for mem_stage (timeout set to 4 cycles).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic [63:0] read_data_out, result_alu_out;
  logic [4:0]  rd_out;
  logic        memtoreg_out, regwrite_out, mem_fault, bus_err;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_funct3(ex_funct3), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .read_data_out(read_data_out),
    .result_alu_out(result_alu_out), .rd_out(rd_out),
    .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out),
    .mem_fault(mem_fault), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        mrd, mwr, regw, m2r;
    logic [4:0]  rd;
    logic [63:0] addr, sdata, rdata;
    int          ack_at;
    bit          perturb;
    int          exp_stall, exp_req;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_wstrb;
    logic        exp_we, exp_fault, exp_err, exp_regw;
    logic [63:0] exp_rdout;
  } vec_t;

  vec_t vecs [13];
  vec_t ld0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  stalls = 0;
    int  reqs   = 0;
    bit  done   = 0;
    bit  fault_seen = 0;
    ex_valid      = 1'b1;
    ex_funct3     = v.f3;
    ex_memread    = v.mrd;
    ex_memwrite   = v.mwr;
    ex_regwrite   = v.regw;
    ex_memtoreg   = v.m2r;
    ex_rd         = v.rd;
    ex_alu_result = v.addr;
    ex_store_data = v.sdata;
    dmem_rdata    = v.rdata;
    dmem_ack      = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (mem_fault) fault_seen = 1;
      if (dmem_req) begin
        reqs++;
        chk({v.name, ".addr"},  dmem_addr,  v.exp_addr);
        chk({v.name, ".wdata"}, dmem_wdata, v.exp_wdata);
        chk({v.name, ".wstrb"}, 64'(dmem_wstrb), 64'(v.exp_wstrb));
        chk({v.name, ".we"},    64'(dmem_we),    64'(v.exp_we));
        if (v.perturb) ex_alu_result = ~v.addr;
        dmem_ack = (reqs == v.ack_at);
      end else begin
        dmem_ack = 1'b0;
      end
      if (stall) stalls++;
      else begin
        done = 1;
        chk({v.name, ".stall_cycles"}, 64'(stalls), 64'(v.exp_stall));
        chk({v.name, ".req_cycles"},   64'(reqs),   64'(v.exp_req));
        chk({v.name, ".mem_fault"},    64'(fault_seen), 64'(v.exp_fault));
        chk({v.name, ".bus_err"},      64'(bus_err),    64'(v.exp_err));
        chk({v.name, ".regwrite"},     64'(regwrite_out), 64'(v.exp_regw));
        chk({v.name, ".read_data"},    read_data_out,   v.exp_rdout);
        chk({v.name, ".alu_out"},      result_alu_out,  v.addr);
        chk({v.name, ".rd_out"},       64'(rd_out),     64'(v.rd));
        chk({v.name, ".memtoreg"},     64'(memtoreg_out), 64'(v.m2r));
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s.done: no completion within 20 cycles", v.name);
    end
    dmem_ack    = 1'b0;
    ex_valid    = 1'b0;
    ex_memread  = 1'b0;
    ex_memwrite = 1'b0;
    ex_regwrite = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"sb", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h1003, 64'hAB, 64'h0, 1, 1'b0,
                 2, 1, 64'h1000, 64'hABABABABABABABAB, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[1]  = '{"lw", 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'h1004, 64'h0, 64'h80000001_12345678, 1, 1'b0,
                 2, 1, 64'h1000, 64'h0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFF80000001};
    vecs[2]  = '{"lwu", 3'b110, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 64'h1004, 64'h0, 64'h80000001_12345678, 1, 1'b0,
                 2, 1, 64'h1000, 64'h0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000000080000001};
    vecs[3]  = '{"lbu", 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 64'h2007, 64'h0, 64'hF000000000000000, 2, 1'b0,
                 3, 2, 64'h2000, 64'h0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 64'hF0};
    vecs[4]  = '{"sw_slow", 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h4000, 64'h11223344DEADBEEF, 64'h0, 4, 1'b1,
                 5, 4, 64'h4000, 64'hDEADBEEFDEADBEEF, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[5]  = '{"lh_mis", 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 64'h3001, 64'h0, 64'h0, 0, 1'b0,
                 0, 0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[6]  = '{"add", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 64'h123456789ABCDEF0, 64'h0, 64'h0, 0, 1'b0,
                 0, 0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
    vecs[7]  = '{"ld_timeout", 3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 64'h5008, 64'h0, 64'hFFFF, 0, 1'b0,
                 5, 4, 64'h5008, 64'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0};
    vecs[8]  = '{"sh", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h6006, 64'hBEEF, 64'h0, 1, 1'b0,
                 2, 1, 64'h6000, 64'hBEEFBEEFBEEFBEEF, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[9]  = '{"lb", 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 64'h7001, 64'h0, 64'h8000, 1, 1'b0,
                 2, 1, 64'h7000, 64'h0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFF80};
    vecs[10] = '{"f3_illegal", 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 64'h8000, 64'h0, 64'h0, 0, 1'b0,
                 0, 0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[11] = '{"lhu", 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 64'h9006, 64'h0, 64'hFFFE000000000000, 3, 1'b0,
                 4, 3, 64'h9000, 64'h0, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFE};
    vecs[12] = '{"sd_mis", 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'hA004, 64'h55, 64'h0, 0, 1'b0,
                 0, 0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    ld0      = '{"ld0", 3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 64'h0, 64'h0, 64'h1122334455667788, 1, 1'b0,
                 2, 1, 64'h0, 64'h0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1122334455667788};

    reset = 1'b1;
    ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_funct3 = '0;
    ex_memread = 1'b0; ex_memwrite = 1'b0; ex_memtoreg = 1'b0; ex_regwrite = 1'b0;
    ex_rd = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req",   64'(dmem_req),   64'h0);
    chk("rst.we",    64'(dmem_we),    64'h0);
    chk("rst.wstrb", 64'(dmem_wstrb), 64'h0);
    chk("rst.addr",  dmem_addr,       64'h0);
    chk("rst.stall", 64'(stall),      64'h0);
    chk("rst.fault", 64'(mem_fault),  64'h0);
    chk("rst.err",   64'(bus_err),    64'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset in the 2nd BUSY cycle abandons the transaction asynchronously.
    ex_valid = 1'b1; ex_funct3 = 3'b011; ex_memread = 1'b1; ex_regwrite = 1'b1;
    ex_alu_result = 64'h10; ex_rd = 5'd4;
    @(negedge clk);
    chk("rstbusy.idle_stall", 64'(stall), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy.busy1_req", 64'(dmem_req), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy.busy2_req", 64'(dmem_req), 64'h1);
    #1 reset = 1'b1;
    #1;
    chk("rstbusy.req_drop",   64'(dmem_req), 64'h0);
    chk("rstbusy.stall_drop", 64'(stall),    64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0;
    @(posedge clk); #1;
    chk("rstbusy.req_after", 64'(dmem_req), 64'h0);
    run_vec(ld0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV64 pipeline. It sits between the EX/MEM register and the MEM/WB register. It takes the EX/MEM-latched instruction, runs a req/ack transaction on the data-memory bus for loads and stores, and formats store lanes and load results. It also stalls the upstream pipeline while a transaction is outstanding, and presents read data, ALU result, rd and control bits to MEM/WB.

## Interface
- TIMEOUT_CYCLES, 255: BUSY cycles without `dmem_ack` before the transaction is abandoned with `bus_err` (1..65535).
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_alu_result  in  64  ALU result; the effective address for loads and stores.
- ex_store_data  in  64  rs2 value for stores.
- ex_funct3  in  3  access size: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 is illegal.
- ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  in  1 each  control bits from EX/MEM.
- ex_rd  in  5  destination register.
- dmem_req  out  1  bus request, held until ack or timeout.
- dmem_we  out  1  1 = store.
- dmem_addr  out  64  doubleword-aligned address (bits [2:0] = 0).
- dmem_wdata  out  64  lane-replicated store data.
- dmem_wstrb  out  8  byte-enable mask.
- dmem_rdata  in  64  load data, valid in the `dmem_ack` cycle.
- dmem_ack  in  1  transaction complete.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- read_data_out  out  64  formatted load data to MEM/WB.
- result_alu_out  out  64  ALU result to MEM/WB.
- rd_out  out  5  destination register to MEM/WB.
- memtoreg_out, regwrite_out  out  1 each  control to MEM/WB.
- mem_fault  out  1  one-cycle pulse: misaligned access or illegal funct3.
- bus_err  out  1  one-cycle pulse: timeout.

## Operation
- A mem op is `ex_valid & (ex_memread | ex_memwrite)`. `off = ex_alu_result[2:0]`.
- Misaligned means: H with off[0] = 1; W with off[1:0] ≠ 0; D with off ≠ 0; or funct3 = 111.
- FSM states are IDLE, BUSY and DONE.
- **IDLE, not a mem op:**
  - Combinational pass-through: `result_alu_out`, `rd_out`, `memtoreg_out` and `regwrite_out` come from the ex_* inputs.
  - `regwrite_out` is gated by `ex_valid`.
  - `read_data_out` = 0, `stall` = 0.
- **IDLE, misaligned mem op:**
  - No bus request; `mem_fault` = 1 this cycle; `stall` = 0.
  - `regwrite_out` = 0; the remaining pass-through outputs are as above.
  - State stays IDLE.
- **IDLE, aligned mem op:**
  - Latch address, formatted wdata/wstrb, we, funct3, off, rd, memtoreg, regwrite and alu_result.
  - `stall` = 1 this cycle; next state is BUSY.
- **BUSY:**
  - `dmem_req` = 1. All `dmem_*` outputs are driven from the latches and held stable.
  - `stall` = 1; the timeout counter increments.
  - On `dmem_ack`: latch the formatted load (0 for stores) and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: drop the request, set an error flag and go to DONE.
- **DONE:**
  - `stall` = 0. Outputs come from the latches; MEM/WB captures them at this edge.
  - On error: `bus_err` = 1 and `regwrite_out` = 0.
  - Next state is IDLE. `dmem_ack` in DONE or IDLE is ignored.
- **Store formatting:**
  - B: wdata = byte replicated ×8, wstrb = 0x01<<off.
  - H: halfword replicated ×4, wstrb = 0x03<<off.
  - W: word replicated ×2, wstrb = 0x0F<<off.
  - D: wdata = data, wstrb = 0xFF.
- **Load formatting:**
  - Shift = `dmem_rdata >> (off*8)`.
  - Take the low 8/16/32/64 bits.
  - B/H/W are sign-extended; BU/HU/WU are zero-extended.

## Timing
- Reset is asynchronous. While reset is asserted:
  - FSM = IDLE; all latches and the counter = 0.
  - `dmem_req`, `dmem_we`, `dmem_wstrb`, `stall`, `mem_fault` and `bus_err` = 0.
  - Latched data/address = 0.
- Reset during BUSY drops `dmem_req` immediately. The abandoned transaction is not retried.
- Stall length: ack in the k-th BUSY cycle (k ≥ 1) gives `stall` high for 1+k cycles. The minimum memory-op occupancy is 3 cycles.
- Timeout: `stall` is high for 1+TIMEOUT_CYCLES cycles, then DONE.
- Non-mem and faulting instructions complete in 1 cycle with no stall.
- Back-to-back mem ops: the second is sampled in the IDLE cycle after DONE. The bus sees `dmem_req` low for at least 2 cycles between transactions.
- `dmem_req` never rises while `dmem_ack` from a prior transaction is still expected.

## Test plan
- SB: data 0x…AB at address 0x1003 -> `dmem_addr` 0x1000, `dmem_wdata` 0xABABABABABABABAB, `dmem_wstrb` 0x08, `dmem_we` 1. Ack on the 1st BUSY cycle -> `stall` high for 2 cycles; `regwrite_out` 0 in DONE.
- LW at 0x1004 with `dmem_rdata` 0x80000001_12345678 -> `read_data_out` 0xFFFFFFFF80000001.
- LWU at the same address and data -> 0x0000000080000001.
- LBU at 0x2007 with rdata 0xF0… -> 0x00000000000000F0.
- Ack delayed to the 4th BUSY cycle -> `stall` high for 5 cycles. `dmem_addr`, `dmem_wdata` and `dmem_wstrb` stay constant while `ex_alu_result` is perturbed.
- LH at 0x3001 -> `mem_fault` 1 for one cycle, no `dmem_req`, `stall` 0, `regwrite_out` 0.
- A non-mem ADD in the same slot passes through unchanged with `read_data_out` 0.
- TIMEOUT_CYCLES = 4, no ack -> `dmem_req` high for 4 cycles, then `bus_err` pulses in DONE with `regwrite_out` 0.
- Reset asserted on the 2nd BUSY cycle -> `dmem_req` and `stall` go to 0 asynchronously.
- After reset release, a new LD at 0x0 completes normally.
